timer_arbiter: RTL and testbench
================================

# timer_arbiter

- Shares one prescaled down-counting timer among `N_REQ` requesters.
- Grants the timer to one requester at a time in round-robin order.
- Counts the granted requester's programmed number of ticks, then pulses that requester's `done`.
- Sits between the system clock and Nexys2 user logic (debouncers, display refresh, LED sequencers) that need one-shot millisecond delays without a dedicated timer each.

## Interface
- `N_REQ`, 4: number of requesters, legal 2..8.
- `LEN_W`, 16: width of each delay length, in ticks.
- `PRESCALE`, 50000: clock cycles per tick, ≥2 (1 ms at 50 MHz).
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  level request per requester.
- `len`  in  N_REQ*LEN_W  delay for requester i in `len[i*LEN_W +: LEN_W]`; sampled only at grant.
- `grant`  out  N_REQ  one-hot, registered; high while requester owns the timer.
- `done`  out  N_REQ  one-hot, one-cycle pulse at end of service.
- `busy`  out  1  high whenever state ≠ IDLE.
- `remain`  out  LEN_W  ticks still to elapse for the current grant; 0 in IDLE.

## Operation
- States:
  - IDLE → LOAD when any `req` bit is high; winner is registered.
  - LOAD → RUN normally; LOAD → DONE if the latched length is 0.
  - RUN → DONE on the last tick.
  - DONE → IDLE unconditionally.
- Arbitration (IDLE only):
  - Search order is `ptr+1, ptr+2, …, ptr` modulo N_REQ; first set `req` bit wins.
  - `ptr` updates to the winner's index in LOAD.
  - Reset value of `ptr` is N_REQ-1, so requester 0 has first priority.
- LOAD:
  - `grant[w]` goes high.
  - `remain` ← `len[w]`.
  - Prescaler cleared to 0.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - On the wrap cycle, `remain` decrements.
  - When `remain` is 1 and the prescaler is at PRESCALE-1, next state is DONE.
  - `req`/`len` changes of other requesters are ignored.
- DONE:
  - `grant` all 0, `done[w]` = 1 for exactly one cycle, `remain` = 0.
- Requester is expected to drop `req` upon `done`. A `req` still high in the following IDLE cycle is a new request, arbitrated with rotated priority.
- Prescaler is idle (held at 0) outside RUN.
- Reset (any state, any cycle) forces:
  - state IDLE, `ptr` = N_REQ-1, prescaler 0;
  - `grant` 0, `done` 0, `busy` 0, `remain` 0.
  - No `done` is issued for an interrupted service.

## Timing
- Request sampled in IDLE at cycle 0.
- `grant[w]` and `busy` rise at cycle 1.
- `grant[w]` is high for cycles 1 .. 1+len·PRESCALE.
- `done[w]` fires at cycle 2+len·PRESCALE; `busy` falls one cycle later.
- len = 0: grant at cycle 1 only, `done` at cycle 2.
- Back-to-back: next arbitration is sampled the cycle after DONE, so there is one IDLE cycle between services.
- Simultaneous requests in IDLE: exactly one grant, chosen by rotation; losers wait with `req` held.
- `remain` arithmetic is unsigned LEN_W; maximum delay is (2^LEN_W − 1)·PRESCALE cycles; no wrap is possible since RUN is never entered with 0.

## Configuration
- `TIMER_ARBITER_ABORT_EN` defined:
  - During RUN, deassertion of `req[w]` aborts the service.
  - Next cycle: state IDLE, `grant` 0, `remain` 0, no `done` pulse.
  - `ptr` keeps the aborted winner's index.
  - Deassertion during LOAD takes effect in the first RUN cycle.
- Macro not defined:
  - `req` is ignored once granted; every granted service runs to DONE and pulses `done`.

## Test plan
All scenarios use PRESCALE=4, N_REQ=4, LEN_W=16.
- Single request:
  - `req`=0001, len0=3 at cycle 0.
  - `grant`=0001 cycles 1–13; `remain` steps 3→2→1 at cycles 5, 9, 13; `done`=0001 at cycle 14 only; `busy` 1–14.
- Zero length:
  - `req`=0100, len2=0.
  - `grant`=0100 at cycle 1 only; `done`=0100 at cycle 2; no RUN cycles.
- Round robin:
  - `req`=1111 held, all len=1.
  - Grant order 0,1,2,3,0; each service 7 cycles apart (LOAD+4 RUN+DONE+IDLE).
- Reset mid-RUN:
  - `reset_n` low at cycle 6 of a len0=3 service.
  - All outputs 0 immediately, no `done`.
  - After release with `req`=0001, grant again goes to requester 0.
- Abort, `TIMER_ARBITER_ABORT_EN` defined:
  - `req0` drops at cycle 7 of a len0=3 service.
  - `grant` 0 at cycle 8, no `done`.
  - Without the macro, `done`=0001 at cycle 14.
- Simultaneous arrival:
  - `req`=1010 after requester 1 was last served.
  - Requester 3 granted first, requester 1 after its `done`.

Source files
------------

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter
// Description : One prescaled down-counting timer shared round-robin among
//               N_REQ requesters. The winner's delay length is latched at
//               grant, counted down in ticks of PRESCALE clocks, and a
//               one-cycle done pulse is returned to that requester.
//               Optional build macro TIMER_ARBITER_ABORT_EN: dropping the
//               granted req during RUN abandons the service without done.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
    parameter int N_REQ    = 4,
    parameter int LEN_W    = 16,
    parameter int PRESCALE = 50000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] len,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [LEN_W-1:0]       remain
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PS_W  = $clog2(PRESCALE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [PS_W-1:0] c_ps_last = PS_W'(PRESCALE - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_win;
    logic [PS_W-1:0]  r_ps;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_done;
    logic [LEN_W-1:0] r_remain;

    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_cand;
    logic [LEN_W-1:0] w_len;
    logic [N_REQ-1:0] w_win_oh;
    logic [N_REQ-1:0] r_win_oh;

    // Rotating-priority search: ptr+1 first, ptr itself last.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_cand  = r_ptr;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = IDX_W'((int'(r_ptr) + i) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_len    = len[w_win*LEN_W +: LEN_W];
    assign w_win_oh = N_REQ'(1) << w_win;
    assign r_win_oh = N_REQ'(1) << r_win;

    // Service sequencer: arbitrate, latch length, count ticks, pulse done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= IDX_W'(N_REQ - 1);
            r_win    <= '0;
            r_ps     <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_remain <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    r_ps <= '0;
                    if (w_found) begin
                        r_state  <= S_LOAD;
                        r_win    <= w_win;
                        r_ptr    <= w_win;
                        r_grant  <= w_win_oh;
                        r_remain <= w_len;
                    end
                end
                S_LOAD: begin
                    r_ps <= '0;
                    // A zero-length delay skips counting entirely.
                    if (r_remain == '0) begin
                        r_state <= S_DONE;
                        r_grant <= '0;
                        r_done  <= r_win_oh;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
`ifdef TIMER_ARBITER_ABORT_EN
                    if (!req[r_win]) begin
                        r_state  <= S_IDLE;
                        r_grant  <= '0;
                        r_remain <= '0;
                        r_ps     <= '0;
                    end else
`endif
                    if (r_ps == c_ps_last) begin
                        r_ps     <= '0;
                        r_remain <= r_remain - LEN_W'(1);
                        if (r_remain == LEN_W'(1)) begin
                            r_state <= S_DONE;
                            r_grant <= '0;
                            r_done  <= r_win_oh;
                        end
                    end else begin
                        r_ps <= r_ps + PS_W'(1);
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_remain <= '0;
                    r_ps     <= '0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_grant  <= '0;
                    r_remain <= '0;
                    r_ps     <= '0;
                end
            endcase
        end
    end

    assign grant  = r_grant;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);
    assign remain = r_remain;

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_arbiter
// Description : Directed bench for timer_arbiter (N_REQ=4, LEN_W=16,
//               PRESCALE=4). A cycle-timeline model predicts all outputs
//               every cycle; literal checks pin key cycles of each scenario.
//               Honours TIMER_ARBITER_ABORT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

    localparam int N  = 4;
    localparam int LW = 16;
    localparam int P  = 4;

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req     = '0;
    logic [N*LW-1:0] len     = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [LW-1:0]   remain;

    int n_cmp = 0;
    int n_bad = 0;
    int cur   = 0;

    timer_arbiter #(
        .N_REQ   (N),
        .LEN_W   (LW),
        .PRESCALE(P)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .len    (len),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .remain (remain)
    );

    always #5 clk = ~clk;

    // Timeline model: m_t counts cycles since the sampling cycle of the
    // current service (1 = grant cycle, 2+len*P = done cycle).
    bit m_act = 1'b0;
    int m_w   = 0;
    int m_len = 0;
    int m_t   = 0;
    int m_ptr = N - 1;

    always @(posedge clk or negedge reset_n) begin : model
        bit found;
        bit abort;
        if (!reset_n) begin
            m_act = 1'b0;
            m_t   = 0;
            m_ptr = N - 1;
        end else if (!m_act) begin
            found = 1'b0;
            for (int i = 1; i <= N; i++) begin
                if (!found && req[(m_ptr + i) % N]) begin
                    found = 1'b1;
                    m_w   = (m_ptr + i) % N;
                end
            end
            if (found) begin
                m_act = 1'b1;
                m_t   = 1;
                m_len = int'(len[m_w*LW +: LW]);
                m_ptr = m_w;
            end
        end else begin
            abort = 1'b0;
`ifdef TIMER_ARBITER_ABORT_EN
            if (m_t >= 2 && m_t <= 1 + m_len * P && !req[m_w]) abort = 1'b1;
`endif
            if (abort || m_t == 2 + m_len * P) m_act = 1'b0;
            else m_t = m_t + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        logic [N-1:0]  eg;
        logic [N-1:0]  ed;
        logic          eb;
        logic [LW-1:0] er;
        eg = '0;
        ed = '0;
        er = '0;
        eb = m_act;
        if (m_act) begin
            if (m_t <= 1 + m_len * P) begin
                eg[m_w] = 1'b1;
                er = (m_t == 1) ? LW'(m_len) : LW'(m_len - (m_t - 2) / P);
            end
            if (m_t == 2 + m_len * P) ed[m_w] = 1'b1;
        end
        n_cmp++;
        if (grant !== eg || done !== ed || busy !== eb || remain !== er) begin
            n_bad++;
            $display("FAIL model t=%0t grant=%b exp %b done=%b exp %b busy=%b exp %b remain=%0d exp %0d",
                     $time, grant, eg, done, ed, busy, eb, remain, er);
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic to(input int c);
        step(c - cur);
        cur = c;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state
        step(2);
        lit("rst_grant", grant, 0);
        lit("rst_done", done, 0);
        lit("rst_busy", busy, 0);
        lit("rst_remain", remain, 0);
        reset_n = 1'b1;
        step(1);

        // Round robin with all requesters, len=1 each
        cur = 0;
        len = {16'd1, 16'd1, 16'd1, 16'd1};
        req = 4'b1111;
        to(1);  lit("rr_g0", grant, 4'b0001);
        to(8);  lit("rr_g1", grant, 4'b0010);
        to(15); lit("rr_g2", grant, 4'b0100);
        to(22); lit("rr_g3", grant, 4'b1000);
        to(29); lit("rr_g0b", grant, 4'b0001);
        to(34); lit("rr_done0", done, 4'b0001);
        req = 4'b0000;
        step(1);

        // Single request, len0=3
        cur = 0;
        len = {16'd0, 16'd0, 16'd0, 16'd3};
        req = 4'b0001;
        to(1);  lit("s1_grant_c1", grant, 4'b0001);
                lit("s1_busy_c1", busy, 1);
                lit("s1_remain_c1", remain, 3);
        to(5);  lit("s1_remain_c5", remain, 3);
        to(6);  lit("s1_remain_c6", remain, 2);
        to(13); lit("s1_grant_c13", grant, 4'b0001);
                lit("s1_remain_c13", remain, 1);
        to(14); lit("s1_done_c14", done, 4'b0001);
                lit("s1_grant_c14", grant, 4'b0000);
                lit("s1_busy_c14", busy, 1);
        req = 4'b0000;
        to(15); lit("s1_busy_c15", busy, 0);
                lit("s1_done_c15", done, 0);

        // Zero length on requester 2
        cur = 0;
        len = {16'd0, 16'd0, 16'd0, 16'd0};
        req = 4'b0100;
        to(1);  lit("z_grant_c1", grant, 4'b0100);
                lit("z_remain_c1", remain, 0);
        to(2);  lit("z_done_c2", done, 4'b0100);
                lit("z_grant_c2", grant, 4'b0000);
        req = 4'b0000;
        to(3);  lit("z_busy_c3", busy, 0);

        // Serve requester 1, then simultaneous 1 and 3
        cur = 0;
        req = 4'b0010;
        to(2);  lit("sim_pre_done", done, 4'b0010);
        req = 4'b0000;
        to(3);
        cur = 0;
        len = {16'd1, 16'd0, 16'd0, 16'd0};
        req = 4'b1010;
        to(1);  lit("sim_grant3", grant, 4'b1000);
        to(6);  lit("sim_done3", done, 4'b1000);
        req = 4'b0010;
        to(8);  lit("sim_grant1", grant, 4'b0010);
        to(9);  lit("sim_done1", done, 4'b0010);
        req = 4'b0000;
        to(10);

        // Reset in the middle of RUN
        cur = 0;
        len = {16'd0, 16'd0, 16'd0, 16'd3};
        req = 4'b0001;
        to(1);  lit("rm_grant_c1", grant, 4'b0001);
        to(6);
        reset_n = 1'b0;
        #1;
        lit("rm_grant_async", grant, 0);
        lit("rm_busy_async", busy, 0);
        lit("rm_remain_async", remain, 0);
        step(2);
        lit("rm_done_held", done, 0);
        reset_n = 1'b1;
        cur = 0;
        to(1);  lit("rm_regrant", grant, 4'b0001);
        to(14); lit("rm_done_c14", done, 4'b0001);
        req = 4'b0000;
        to(15);

        // req0 dropped mid-service
        cur = 0;
        req = 4'b0001;
        to(7);
        req = 4'b0000;
`ifdef TIMER_ARBITER_ABORT_EN
        to(8);  lit("ab_grant_c8", grant, 0);
                lit("ab_busy_c8", busy, 0);
                lit("ab_remain_c8", remain, 0);
        to(14); lit("ab_done_c14", done, 0);
`else
        to(8);  lit("ab_grant_c8", grant, 4'b0001);
                lit("ab_remain_c8", remain, 2);
        to(14); lit("ab_done_c14", done, 4'b0001);
`endif
        to(16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
